// File: rtl/time_set_ctrl.sv
// time_set_ctrl: run/set sequencer for the hh:mm:ss time-of-day counter.
// Generates the one-second count enable in RUN, and lets the user edit
// hour/minute/second with mode/inc/dec buttons before a one-cycle load.
module time_set_ctrl #(
  parameter int unsigned CLK_DIV   = 50_000_000,
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       tick_en,
  output logic       load,
  output logic [5:0] load_hour,
  output logic [5:0] load_min,
  output logic [5:0] load_sec,
  output logic [1:0] edit_field,
  output logic       blink
);

  localparam int unsigned FW = 6;
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_S + 1);

  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_DIV / 2);
  localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT_S);
  localparam logic [FW-1:0] HOUR_MAX   = FW'(23);
  localparam logic [FW-1:0] MS_MAX     = FW'(59);
  localparam logic [FW-1:0] HOUR_LIM   = FW'(24);
  localparam logic [FW-1:0] MS_LIM     = FW'(60);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SET_HOUR,
    ST_SET_MIN,
    ST_SET_SEC,
    ST_COMMIT
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            btn_mode_q, btn_inc_q, btn_dec_q;
  logic [FW-1:0]   edit_hour_q, edit_hour_d;
  logic [FW-1:0]   edit_min_q, edit_min_d;
  logic [FW-1:0]   edit_sec_q, edit_sec_d;
  logic            tick_en_q, tick_en_d;
  logic            load_q, load_d;
  logic [FW-1:0]   load_hour_q, load_hour_d;
  logic [FW-1:0]   load_min_q, load_min_d;
  logic [FW-1:0]   load_sec_q, load_sec_d;

  logic            rise_mode, rise_inc, rise_dec, any_rise;
  logic            sec_pulse;
  logic [TW-1:0]   tmo_inc;

  // Increment with explicit wrap at max back to zero.
  function automatic logic [FW-1:0] wrap_inc(input logic [FW-1:0] v,
                                             input logic [FW-1:0] max);
    return (v >= max) ? '0 : v + FW'(1);
  endfunction

  // Decrement with explicit wrap from zero up to max.
  function automatic logic [FW-1:0] wrap_dec(input logic [FW-1:0] v,
                                             input logic [FW-1:0] max);
    return (v == '0) ? max : v - FW'(1);
  endfunction

  // Button edges, one-second strobe and timeout increment.
  always_comb begin
    rise_mode = btn_mode & ~btn_mode_q;
    rise_inc  = btn_inc  & ~btn_inc_q;
    rise_dec  = btn_dec  & ~btn_dec_q;
    any_rise  = rise_mode | rise_inc | rise_dec;
    sec_pulse = (presc_q == PRESC_MAX);
    tmo_inc   = tmo_q + TW'(1);
  end

  // Next-state, edit-field and output computation.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    edit_hour_d = edit_hour_q;
    edit_min_d  = edit_min_q;
    edit_sec_d  = edit_sec_q;
    load_hour_d = load_hour_q;
    load_min_d  = load_min_q;
    load_sec_d  = load_sec_q;

    // Prescaler free-runs everywhere; COMMIT restarts the second boundary.
    if (state_q == ST_COMMIT) begin
      presc_d = '0;
    end else if (sec_pulse) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    case (state_q)
      ST_RUN: begin
        tmo_d = '0;
        if (rise_mode) begin
          state_d     = ST_SET_HOUR;
          edit_hour_d = (cur_hour >= HOUR_LIM) ? '0 : cur_hour;
          edit_min_d  = (cur_min  >= MS_LIM)   ? '0 : cur_min;
          edit_sec_d  = (cur_sec  >= MS_LIM)   ? '0 : cur_sec;
        end
      end

      ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
        if (any_rise) begin
          tmo_d = '0;
        end else if (sec_pulse) begin
          tmo_d = tmo_inc;
        end

        if (rise_mode) begin
          case (state_q)
            ST_SET_HOUR: state_d = ST_SET_MIN;
            ST_SET_MIN:  state_d = ST_SET_SEC;
            default:     state_d = ST_COMMIT;
          endcase
        end else if (!any_rise && sec_pulse && (tmo_inc == TMO_LIMIT)) begin
          state_d = ST_RUN;
          tmo_d   = '0;
        end else if (rise_inc != rise_dec) begin
          case (state_q)
            ST_SET_HOUR: edit_hour_d = rise_inc ? wrap_inc(edit_hour_q, HOUR_MAX)
                                                : wrap_dec(edit_hour_q, HOUR_MAX);
            ST_SET_MIN:  edit_min_d  = rise_inc ? wrap_inc(edit_min_q, MS_MAX)
                                                : wrap_dec(edit_min_q, MS_MAX);
            default:     edit_sec_d  = rise_inc ? wrap_inc(edit_sec_q, MS_MAX)
                                                : wrap_dec(edit_sec_q, MS_MAX);
          endcase
        end
      end

      ST_COMMIT: begin
        state_d = ST_RUN;
        tmo_d   = '0;
      end

      default: begin
        state_d = ST_RUN;
        tmo_d   = '0;
      end
    endcase

    tick_en_d = (state_q == ST_RUN) && sec_pulse;
    load_d    = (state_d == ST_COMMIT);
    if (load_d) begin
      load_hour_d = edit_hour_d;
      load_min_d  = edit_min_d;
      load_sec_d  = edit_sec_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      presc_q     <= '0;
      tmo_q       <= '0;
      btn_mode_q  <= 1'b0;
      btn_inc_q   <= 1'b0;
      btn_dec_q   <= 1'b0;
      edit_hour_q <= '0;
      edit_min_q  <= '0;
      edit_sec_q  <= '0;
      tick_en_q   <= 1'b0;
      load_q      <= 1'b0;
      load_hour_q <= '0;
      load_min_q  <= '0;
      load_sec_q  <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tmo_q       <= tmo_d;
      btn_mode_q  <= btn_mode;
      btn_inc_q   <= btn_inc;
      btn_dec_q   <= btn_dec;
      edit_hour_q <= edit_hour_d;
      edit_min_q  <= edit_min_d;
      edit_sec_q  <= edit_sec_d;
      tick_en_q   <= tick_en_d;
      load_q      <= load_d;
      load_hour_q <= load_hour_d;
      load_min_q  <= load_min_d;
      load_sec_q  <= load_sec_d;
    end
  end

  // Field select decode and blink phase for the display.
  always_comb begin
    case (state_q)
      ST_SET_HOUR: edit_field = 2'd1;
      ST_SET_MIN:  edit_field = 2'd2;
      ST_SET_SEC:  edit_field = 2'd3;
      ST_COMMIT:   edit_field = 2'd3;
      default:     edit_field = 2'd0;
    endcase
    blink = ((state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN) ||
             (state_q == ST_SET_SEC)) && (presc_q >= PRESC_HALF);
  end

  assign tick_en   = tick_en_q;
  assign load      = load_q;
  assign load_hour = load_hour_q;
  assign load_min  = load_min_q;
  assign load_sec  = load_sec_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed bench with a per-cycle reference model of the
// clock set controller plus literal expectations from the test plan.
module tb_time_set_ctrl;

  localparam int DIV = 10;
  localparam int TMO = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [5:0] cur_hour = '0, cur_min = '0, cur_sec = '0;
  logic       tick_en, load, blink;
  logic [5:0] load_hour, load_min, load_sec;
  logic [1:0] edit_field;

  time_set_ctrl #(.CLK_DIV(DIV), .TIMEOUT_S(TMO)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .tick_en(tick_en), .load(load),
    .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
    .edit_field(edit_field), .blink(blink)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=run, 1..3=hour/min/sec, 4=commit.
  int m_mode, m_pres, m_tmo, eh, em, es, lh, lm, ls;
  bit m_tick, m_load, pm, pi, pd;

  task automatic model_reset();
    m_mode = 0; m_pres = 0; m_tmo = 0;
    eh = 0; em = 0; es = 0; lh = 0; lm = 0; ls = 0;
    m_tick = 0; m_load = 0; pm = 0; pi = 0; pd = 0;
  endtask

  task automatic model_step(input bit bm, input bit bi, input bit bd,
                            input int ch, input int cm, input int cs);
    bit rm, ri, rd, sp;
    int nm;
    rm = bm && !pm; ri = bi && !pi; rd = bd && !pd;
    sp = (m_pres == DIV - 1);
    m_tick = (m_mode == 0) && sp;
    nm = m_mode;
    if (m_mode == 4) begin
      nm = 0;
    end else if (m_mode == 0) begin
      if (rm) begin
        nm = 1; m_tmo = 0;
        eh = (ch >= 24) ? 0 : ch;
        em = (cm >= 60) ? 0 : cm;
        es = (cs >= 60) ? 0 : cs;
      end
    end else begin
      if (rm) nm = m_mode + 1;
      else if (ri && !rd) begin
        if (m_mode == 1) eh = (eh + 1) % 24;
        else if (m_mode == 2) em = (em + 1) % 60;
        else es = (es + 1) % 60;
      end else if (rd && !ri) begin
        if (m_mode == 1) eh = (eh + 23) % 24;
        else if (m_mode == 2) em = (em + 59) % 60;
        else es = (es + 59) % 60;
      end
      if (rm || ri || rd) m_tmo = 0;
      else if (sp) begin
        m_tmo++;
        if (m_tmo == TMO) begin nm = 0; m_tmo = 0; end
      end
    end
    m_load = (nm == 4);
    if (m_load) begin lh = eh; lm = em; ls = es; end
    m_pres = (m_mode == 4) ? 0 : (m_pres + 1) % DIV;
    m_mode = nm;
    pm = bm; pi = bi; pd = bd;
  endtask

  // Observation bookkeeping for the literal checks.
  int cyc = 0;
  int tick_cnt = 0, first_tick = -1, set_tick_cnt = 0;
  int load_cnt = 0, load_cyc = 0, post_tick_cyc = 0;
  bit post_seen = 1'b1;
  int cap_h = 0, cap_m = 0, cap_s = 0;

  // Step the model on every edge and compare all outputs just after it.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      model_reset();
    end else begin
      model_step(btn_mode, btn_inc, btn_dec, cur_hour, cur_min, cur_sec);
      #1;
      check("tick_en", tick_en, m_tick);
      check("load", load, m_load);
      check("load_hour", load_hour, lh);
      check("load_min", load_min, lm);
      check("load_sec", load_sec, ls);
      check("edit_field", edit_field, (m_mode == 4) ? 3 : m_mode);
      check("blink", blink, (m_mode >= 1 && m_mode <= 3 && m_pres >= DIV / 2) ? 1 : 0);
      if (tick_en === 1'b1) begin
        tick_cnt++;
        if (first_tick < 0) first_tick = cyc;
        if (edit_field != 2'd0) set_tick_cnt++;
      end
      if (load === 1'b1) begin
        load_cnt++; load_cyc = cyc; post_seen = 1'b0;
        cap_h = load_hour; cap_m = load_min; cap_s = load_sec;
      end
      if (tick_en === 1'b1 && !post_seen) begin
        post_tick_cyc = cyc; post_seen = 1'b1;
      end
    end
  end

  // One-cycle button press; m/i/d select which buttons rise together.
  task automatic press(input bit m, input bit i, input bit d);
    btn_mode = m; btn_inc = i; btn_dec = d;
    @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hour = 6'(h); cur_min = 6'(m); cur_sec = 6'(s);
  endtask

  task automatic check_load(input string name, input int h, input int m, input int s, input int cnt);
    check({name, "_cnt"}, load_cnt, cnt);
    check({name, "_h"}, cap_h, h);
    check({name, "_m"}, cap_m, m);
    check({name, "_s"}, cap_s, s);
  endtask

  int rel_cyc;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_edit_field", edit_field, 0);
    check("rst_tick_en", tick_en, 0);
    check("rst_load_hour", load_hour, 0);

    // Free-running tick after reset release.
    reset = 1'b0;
    rel_cyc = cyc;
    repeat (35) @(negedge clk);
    check("first_tick_delay", first_tick - rel_cyc, 10);
    check("tick_count_35", tick_cnt, 3);
    check("no_load_run", load_cnt, 0);

    // Basic edit: 12:34:56 -> 14:33:56.
    set_cur(12, 34, 56);
    press(1, 0, 0);
    check("ef_hour", edit_field, 1);
    press(0, 1, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    check("ef_min", edit_field, 2);
    press(0, 0, 1);
    press(1, 0, 0);
    check("ef_sec", edit_field, 3);
    press(1, 0, 0);
    check_load("basic", 14, 33, 56, 1);
    check("no_tick_in_set", set_tick_cnt, 0);
    repeat (15) @(negedge clk);
    check("tick_after_load", post_tick_cyc - load_cyc, 11);

    // Wraps: 23:59:00 -> 00:00:59.
    set_cur(23, 59, 0);
    press(1, 0, 0); press(0, 1, 0);
    press(1, 0, 0); press(0, 1, 0);
    press(1, 0, 0); press(0, 0, 1);
    press(1, 0, 0);
    check_load("wrap", 0, 0, 59, 2);
    repeat (3) @(negedge clk);

    // Out-of-range capture clamps to 0; hour dec wraps 0 -> 23.
    set_cur(30, 61, 60);
    press(1, 0, 0); press(0, 0, 1);
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    check_load("clamp", 23, 0, 0, 3);
    repeat (3) @(negedge clk);

    // Simultaneous rises.
    set_cur(5, 10, 20);
    press(1, 0, 0);
    press(1, 1, 0);
    check("ef_mode_inc", edit_field, 2);
    press(0, 1, 1);
    press(1, 0, 0); press(1, 0, 0);
    check_load("simul", 5, 10, 20, 4);
    repeat (3) @(negedge clk);

    // Timeout with a restart in the middle.
    set_cur(1, 2, 3);
    press(1, 0, 0);
    repeat (15) @(negedge clk);
    check("tmo_still_set_a", edit_field, 1);
    press(0, 1, 0);
    repeat (15) @(negedge clk);
    check("tmo_restarted", edit_field, 1);
    repeat (25) @(negedge clk);
    check("tmo_expired", edit_field, 0);
    check("tmo_no_load", load_cnt, 4);
    check("tmo_load_hold", load_hour, 5);

    // Reset in the middle of an edit, mode held across release.
    set_cur(8, 9, 10);
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    check("pre_rst_ef", edit_field, 3);
    reset = 1'b1;
    btn_mode = 1'b1;
    #1;
    check("rst_mid_ef", edit_field, 0);
    check("rst_mid_blink", blink, 0);
    check("rst_mid_load", load, 0);
    check("rst_mid_load_hour", load_hour, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    check("held_mode_entry", edit_field, 1);
    @(negedge clk);
    btn_mode = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_no_load", load_cnt, 4);
    check("rst_final_ef", edit_field, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
